axis_byte_packer: RTL and testbench

//  AXI-stream byte-to-word packer. Sits directly downstream of the byte-serial
//  AXI-stream transmitter and consumes its 8-bit beats. Packs them LSB-first into
//  64-bit words with a byte-keep mask. Buffers completed words in a small output

---
 rtl/axis_byte_packer.sv | 122 ++++++++++++
 tb/tb_axis_byte_packer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_byte_packer.sv
// axis_byte_packer: packs an 8-bit AXI-stream LSB-first into N_BYTES-wide words with keep/last,
// buffered in a small first-word-fall-through FIFO with registered backpressure.
`default_nettype none

module axis_byte_packer #(
  parameter int N_BYTES    = 8,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [8*N_BYTES-1:0] m_data,
  output logic [N_BYTES-1:0]   m_keep,
  output logic                 m_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [CNT_W-1:0]     frame_cnt
);

  localparam int IDX_W  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_FW = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W  = 8*N_BYTES + N_BYTES + 1;

  typedef enum logic [0:0] {IDLE = 1'b0, COLLECT = 1'b1} state_t;

  state_t                 state;
  logic [8*N_BYTES-1:0]   acc;
  logic [N_BYTES-1:0]     keep;
  logic [IDX_W-1:0]       idx;
  logic [ENT_W-1:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_FW-1:0]      fifo_count;

  logic                   accept;
  logic                   complete;
  logic                   push;
  logic                   pop;
  logic [8*N_BYTES-1:0]   acc_next;
  logic [N_BYTES-1:0]     keep_next;
  logic [CNT_FW-1:0]      count_next;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign accept   = s_valid & s_ready;
  assign complete = (idx == IDX_W'(N_BYTES - 1)) | s_last;
  assign push     = accept & complete;
  assign pop      = m_valid & m_ready;

  assign m_valid = (fifo_count != '0);
  assign {m_data, m_keep, m_last} = mem[rd_ptr];

  // Merged view of the word including the current beat; this is what gets pushed.
  always_comb begin
    acc_next                 = acc;
    keep_next                = keep;
    acc_next[{idx, 3'b000} +: 8] = s_data;
    keep_next[idx]           = 1'b1;
  end

  always_comb begin
    count_next = fifo_count;
    if (push && !pop)
      count_next = fifo_count + 1'b1;
    else if (!push && pop)
      count_next = fifo_count - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      acc        <= '0;
      keep       <= '0;
      idx        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      s_ready    <= 1'b0;
      frame_cnt  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (accept) begin
        case (state)
          IDLE:    if (!s_last) state <= COLLECT;
          COLLECT: if (s_last) state <= IDLE;
          default: state <= IDLE;
        endcase
        if (complete) begin
          acc  <= '0;
          keep <= '0;
          idx  <= '0;
        end else begin
          acc  <= acc_next;
          keep <= keep_next;
          idx  <= idx + 1'b1;
        end
      end
      if (push) begin
        mem[wr_ptr] <= {acc_next, keep_next, s_last};
        wr_ptr      <= ptr_inc(wr_ptr);
        if (s_last)
          frame_cnt <= frame_cnt + 1'b1;
      end
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
      fifo_count <= count_next;
      // Registered ready: a full FIFO popped this cycle still refuses the beat.
      s_ready    <= (count_next < CNT_FW'(FIFO_DEPTH));
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axis_byte_packer.sv
// tb_axis_byte_packer: table-driven frames plus hand-written corner sequences, checked
// against a bench-side packing model through a scoreboard queue.
`timescale 1ns/1ps

module tb_axis_byte_packer;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic [63:0]   m_data;
  logic [7:0]    m_keep;
  logic          m_last;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [CW-1:0] frame_cnt;

  axis_byte_packer #(.N_BYTES(8), .FIFO_DEPTH(2), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_keep(m_keep), .m_last(m_last), .m_valid(m_valid),
    .m_ready(m_ready), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef logic [72:0] word_t;
  typedef struct {
    int         len;
    logic [7:0] base;
    int         exp_words;
    logic [7:0] exp_keep;
  } vec_t;

  word_t      sb[$];
  int         checks = 0;
  int         errors = 0;
  int         words_seen = 0;
  logic [7:0] last_keep_seen = '0;
  logic [63:0] mdl_acc = '0;
  logic [7:0]  mdl_keep = '0;
  int          mdl_idx = 0;
  int          mdl_fc = 0;
  logic        done5 = 1'b0;

  task automatic chk(input string nm, input logic [72:0] act, input logic [72:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Output monitor: a transfer seen at negedge completes at the following posedge.
  initial begin
    word_t cur;
    word_t held;
    logic  hold_pend;
    hold_pend = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_pend = 1'b0;
      end else begin
        cur = {m_data, m_keep, m_last};
        if (hold_pend && m_valid)
          chk("hold_stable", cur, held);
        hold_pend = m_valid && !m_ready;
        held = cur;
        if (m_valid && m_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_word", cur, '0);
          end else begin
            chk("word", cur, sb.pop_front());
          end
          words_seen++;
          if (m_last) last_keep_seen = m_keep;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n;
    mdl_acc[8*mdl_idx +: 8] = d;
    mdl_keep[mdl_idx] = 1'b1;
    if (mdl_idx == 7 || l) begin
      sb.push_back({mdl_acc, mdl_keep, l});
      mdl_acc = '0;
      mdl_keep = '0;
      mdl_idx = 0;
      if (l) mdl_fc++;
    end else begin
      mdl_idx++;
    end
    s_data = d;
    s_last = l;
    s_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!s_ready) chk("s_ready_timeout", 73'(s_ready), 73'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
  endtask

  task automatic send_frame(input int len, input logic [7:0] base);
    for (int i = 0; i < len; i++)
      send_byte(base + 8'(i), i == len - 1);
  endtask

  task automatic drain();
    int n;
    m_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 73'(sb.size()), 73'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    s_valid = 1'b0;
    sb.delete();
    mdl_acc = '0;
    mdl_keep = '0;
    mdl_idx = 0;
    mdl_fc = 0;
    #1;
    chk("rst_m_valid", 73'(m_valid), 73'd0);
    chk("rst_frame_cnt", 73'(frame_cnt), 73'd0);
    chk("rst_s_ready", 73'(s_ready), 73'd0);
    chk("rst_head", {m_data, m_keep, m_last}, 73'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_s_ready", 73'(s_ready), 73'd1);
  endtask

  initial begin
    vec_t tbl[6];
    int   w0;
    tbl[0] = '{11, 8'h20, 2, 8'h07};
    tbl[1] = '{1,  8'h40, 1, 8'h01};
    tbl[2] = '{16, 8'h50, 2, 8'hFF};
    tbl[3] = '{7,  8'h70, 1, 8'h7F};
    tbl[4] = '{9,  8'h90, 2, 8'h01};
    tbl[5] = '{8,  8'hA0, 1, 8'hFF};

    // Reset state, then a partial frame discarded by a mid-frame reset.
    do_reset();
    for (int i = 0; i < 5; i++) send_byte(8'hC0 + 8'(i), 1'b0);
    chk("partial_no_word", 73'(m_valid), 73'd0);
    do_reset();
    w0 = words_seen;
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b1);
    chk("3byte_head", {m_data, m_keep, m_last}, {64'h0000_0000_0033_2211, 8'h07, 1'b1});
    drain();
    chk("3byte_words", 73'(words_seen - w0), 73'd1);

    // Exact 8-byte frame: one-cycle latency, single word.
    do_reset();
    w0 = words_seen;
    for (int i = 1; i <= 7; i++) send_byte(8'(i), 1'b0);
    chk("lat_pre", 73'(m_valid), 73'd0);
    send_byte(8'h08, 1'b1);
    chk("lat_1cyc", 73'(m_valid), 73'd1);
    chk("8byte_head", {m_data, m_keep, m_last}, {64'h0807_0605_0403_0201, 8'hFF, 1'b1});
    drain();
    chk("8byte_frame_cnt", 73'(frame_cnt), 73'd1);
    chk("8byte_words", 73'(words_seen - w0), 73'd1);

    for (int t = 0; t < 6; t++) begin
      w0 = words_seen;
      send_frame(tbl[t].len, tbl[t].base);
      drain();
      chk($sformatf("tbl%0d_words", t), 73'(words_seen - w0), 73'(tbl[t].exp_words));
      chk($sformatf("tbl%0d_keep", t), 73'(last_keep_seen), 73'(tbl[t].exp_keep));
      chk($sformatf("tbl%0d_fcnt", t), 73'(frame_cnt), 73'(mdl_fc % 16));
    end

    // Backpressure: two words fill the FIFO, third frame waits, head held.
    w0 = words_seen;
    m_ready = 1'b0;
    send_frame(8, 8'h10);
    send_frame(8, 8'h20);
    chk("full_s_ready", 73'(s_ready), 73'd0);
    chk("full_head", 73'(m_data), 73'(64'h1716_1514_1312_1110));
    fork
      send_frame(8, 8'h30);
      begin
        repeat (6) @(posedge clk);
        #1;
        chk("bp_hold_head", 73'(m_data), 73'(64'h1716_1514_1312_1110));
        chk("bp_s_ready", 73'(s_ready), 73'd0);
        m_ready = 1'b1;
      end
    join
    drain();
    chk("bp_words", 73'(words_seen - w0), 73'd3);

    // One-byte frames back to back with a random consumer.
    w0 = words_seen;
    fork
      begin
        for (int i = 0; i < 20; i++) send_byte(8'($urandom), 1'b1);
        done5 = 1'b1;
      end
      begin
        while (!done5) begin
          @(posedge clk);
          #1;
          m_ready = 1'($urandom);
        end
      end
    join
    drain();
    chk("rand_words", 73'(words_seen - w0), 73'd20);
    chk("rand_keep", 73'(last_keep_seen), 73'd1);
    chk("rand_fcnt", 73'(frame_cnt), 73'(mdl_fc % 16));

    // frame_cnt wrap at 4 bits.
    do_reset();
    for (int i = 0; i < 15; i++) send_byte(8'(i), 1'b1);
    chk("wrap_15", 73'(frame_cnt), 73'd15);
    send_byte(8'hEE, 1'b1);
    chk("wrap_0", 73'(frame_cnt), 73'd0);
    send_byte(8'hEF, 1'b1);
    chk("wrap_1", 73'(frame_cnt), 73'd1);
    drain();
    chk("sb_empty", 73'(sb.size()), 73'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
